mvu_weight_seq: RTL and testbench
=================================

# mvu_weight_seq

Sequencing controller for the MVAU weight memory bank and input-vector buffer. Walks the weight address space in neuron-fold-major order (addr = nf*SF + sf), consumes one SIMD-wide input word per synapse fold on the first neuron fold, then replays the buffered vector for the remaining folds. Emits per-cycle accumulator control aligned to the one-cycle read latency of the weight memories, and applies downstream backpressure.

## Interface
- SIMD, 2, input elements per word
- PE, 2, processing elements (weight memories)
- MATRIXW, 4, matrix columns; must be a multiple of SIMD
- MATRIXH, 4, matrix rows; must be a multiple of PE
- SF (derived), MATRIXW/SIMD, synapse folds
- NF (derived), MATRIXH/PE, neuron folds
- WMEM_DEPTH (derived), SF*NF
- WMEM_ADDR_BW (derived), $clog2(WMEM_DEPTH) if >1, else 1
- IBUF_ADDR_BW (derived), $clog2(SF) if >1, else 1

- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- run  in  1  level; low parks the sequencer after the current vector
- in_valid  in  1  input stream word valid
- in_ready  out  1  input word accepted when in_valid && in_ready
- stall  in  1  downstream not ready; freezes all advancing state
- wmem_addr  out  WMEM_ADDR_BW  weight memory address (broadcast to all PE)
- ibuf_we  out  1  write current input word to buffer at ibuf_waddr
- ibuf_waddr  out  IBUF_ADDR_BW  buffer write address (= sf)
- ibuf_raddr  out  IBUF_ADDR_BW  buffer read address (= sf)
- src_sel  out  1  1-cycle delayed: 0 = use registered stream word, 1 = use buffer data
- acc_valid  out  1  1-cycle delayed: weight data and input valid this cycle
- acc_first  out  1  1-cycle delayed: sf==0, clear accumulator
- acc_last  out  1  1-cycle delayed: sf==SF-1, result of PE rows complete
- vec_done  out  1  1-cycle delayed pulse: last beat of last neuron fold

## Operation
- Counters sf (0..SF-1), nf (0..NF-1); wmem_addr registered = nf*SF+sf.
- States: IDLE, FILL, REUSE. Reset -> IDLE, sf=nf=0, all outputs 0.
- IDLE: in_ready=0. Go FILL when run=1.
- FILL (nf==0): in_ready = !stall. Beat fires on in_valid && !stall: ibuf_we=1, sf increments. At sf==SF-1 beat: sf->0; nf->1 and state REUSE if NF>1, else vector complete.
- REUSE (nf>0): in_ready=0; beat fires each cycle with !stall; sf increments; at sf==SF-1, nf increments. At sf==SF-1 and nf==NF-1: vector complete.
- Vector complete: sf=nf=0; next state FILL if run=1, else IDLE.
- stall=1: no beat, counters and state hold, in_ready=0, acc_valid=0 next cycle; ibuf_we=0.
- run deasserted mid-vector is ignored until vector completion.
- reset mid-vector: immediate return to IDLE, counters 0, delayed outputs cleared next edge.

## Timing
- Beat issued cycle t: wmem_addr presented at t; weight data valid t+1; acc_valid/acc_first/acc_last/src_sel/vec_done asserted at t+1.
- Throughput: one beat per cycle when in_valid=1 (FILL) and stall=0; no bubbles between folds or between back-to-back vectors.
- IDLE -> FILL costs one cycle; wmem_addr is 0 during IDLE.
- ibuf_we and ibuf_waddr are same-cycle with the accepted input word.

## Configuration
- MVU_WEIGHT_SEQ_PERF_EN defined: adds out ports vec_count[31:0] (increments per vec_done) and stall_count[31:0] (increments each cycle stall=1 outside IDLE); both cleared by reset, wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- SIMD=PE=2, MATRIXW=MATRIXH=4, in_valid=1, stall=0, run=1: wmem_addr 0,1,2,3,0,...; acc_first at beats 0,2; acc_last at 1,3; vec_done at t+1 of addr 3; in_ready high only for addr 0,1.
- Same config, in_valid toggling 1,0,1: FILL advances only on accepted beats; wmem_addr holds 0→0→1; acc_valid gaps match.
- stall=1 for 3 cycles during REUSE at addr 2: addr holds 2, acc_valid=0 three cycles, resumes 3 with no lost beat.
- run dropped at addr 1: sequence finishes 2,3, vec_done pulses, state IDLE, in_ready=0, addr 0.
- reset asserted at addr 2: next cycle IDLE, all outputs 0; rerun restarts at addr 0 in FILL.
- With MVU_WEIGHT_SEQ_PERF_EN, 3 vectors with 5 stall cycles: vec_count=3, stall_count=5.

Source files
------------

// File: rtl/mvu_weight_seq.sv
// Weight-address / input-buffer sequencer for the MVAU: walks addr = nf*SF + sf, fills the vector buffer on nf==0 and replays it on the later folds.
// Latency: wmem_addr, in_ready and ibuf_* act in the beat cycle; acc_* and vec_done follow one cycle later. Backpressure: stall freezes everything.
// Optional MVU_WEIGHT_SEQ_PERF_EN adds vec_count_o / stall_count_o performance counters.
module mvu_weight_seq #(
    parameter int SIMD    = 2,
    parameter int PE      = 2,
    parameter int MATRIXW = 4,
    parameter int MATRIXH = 4,
    localparam int SF           = MATRIXW / SIMD,
    localparam int NF           = MATRIXH / PE,
    localparam int WMEM_DEPTH   = SF * NF,
    localparam int WMEM_ADDR_BW = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1,
    localparam int IBUF_ADDR_BW = (SF > 1) ? $clog2(SF) : 1,
    localparam int NF_BW        = (NF > 1) ? $clog2(NF) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    run_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic                    stall_i,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr_o,
    output logic                    ibuf_we_o,
    output logic [IBUF_ADDR_BW-1:0] ibuf_waddr_o,
    output logic [IBUF_ADDR_BW-1:0] ibuf_raddr_o,
    output logic                    src_sel_o,
    output logic                    acc_valid_o,
    output logic                    acc_first_o,
    output logic                    acc_last_o,
    output logic                    vec_done_o
`ifdef MVU_WEIGHT_SEQ_PERF_EN
    ,
    output logic [31:0]             vec_count_o,
    output logic [31:0]             stall_count_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_REUSE} state_t;

    localparam logic [IBUF_ADDR_BW-1:0] SF_LAST = IBUF_ADDR_BW'(SF - 1);
    localparam logic [NF_BW-1:0]        NF_LAST = NF_BW'(NF - 1);

    state_t                  state_q, state_d;
    logic [IBUF_ADDR_BW-1:0] sf_q, sf_d;
    logic [NF_BW-1:0]        nf_q, nf_d;
    logic [WMEM_ADDR_BW-1:0] addr_q, addr_d;
    logic                    src_sel_q, acc_valid_q, acc_first_q, acc_last_q, vec_done_q;
    logic                    fill_beat, beat, sf_end, vec_end;

    always_comb begin
        in_ready_o = (state_q == S_FILL) && !stall_i;
        fill_beat  = in_ready_o && in_valid_i;
        beat       = fill_beat || ((state_q == S_REUSE) && !stall_i);
        sf_end     = (sf_q == SF_LAST);
        vec_end    = beat && sf_end && (nf_q == NF_LAST);

        state_d = state_q;
        sf_d    = sf_q;
        nf_d    = nf_q;
        addr_d  = addr_q;
        if (state_q == S_IDLE) begin
            if (run_i) state_d = S_FILL;
        end else if (beat) begin
            // Address is a flat running count; it wraps to 0 only at vector end.
            addr_d = addr_q + WMEM_ADDR_BW'(1);
            if (!sf_end) begin
                sf_d = sf_q + IBUF_ADDR_BW'(1);
            end else if (vec_end) begin
                sf_d    = '0;
                nf_d    = '0;
                addr_d  = '0;
                state_d = run_i ? S_FILL : S_IDLE;
            end else begin
                sf_d    = '0;
                nf_d    = nf_q + NF_BW'(1);
                state_d = S_REUSE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            sf_q        <= '0;
            nf_q        <= '0;
            addr_q      <= '0;
            src_sel_q   <= 1'b0;
            acc_valid_q <= 1'b0;
            acc_first_q <= 1'b0;
            acc_last_q  <= 1'b0;
            vec_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sf_q        <= sf_d;
            nf_q        <= nf_d;
            addr_q      <= addr_d;
            src_sel_q   <= beat && (state_q == S_REUSE);
            acc_valid_q <= beat;
            acc_first_q <= beat && (sf_q == '0);
            acc_last_q  <= beat && sf_end;
            vec_done_q  <= vec_end;
        end
    end

    assign wmem_addr_o  = addr_q;
    assign ibuf_we_o    = fill_beat;
    assign ibuf_waddr_o = sf_q;
    assign ibuf_raddr_o = sf_q;
    assign src_sel_o    = src_sel_q;
    assign acc_valid_o  = acc_valid_q;
    assign acc_first_o  = acc_first_q;
    assign acc_last_o   = acc_last_q;
    assign vec_done_o   = vec_done_q;

`ifdef MVU_WEIGHT_SEQ_PERF_EN
    logic [31:0] vec_cnt_q, stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vec_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (vec_end) vec_cnt_q <= vec_cnt_q + 32'd1;
            if (stall_i && (state_q != S_IDLE)) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign vec_count_o   = vec_cnt_q;
    assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mvu_weight_seq.sv
// Self-checking bench for mvu_weight_seq (SIMD=PE=2, 4x4 matrix): behavioural model plus a queue of expected delayed-output records.
module tb_mvu_weight_seq;
    localparam int SF = 2;
    localparam int NF = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       in_valid = 1'b0;
    logic       stall = 1'b0;
    logic       in_ready;
    logic [1:0] wmem_addr;
    logic       ibuf_we;
    logic [0:0] ibuf_waddr, ibuf_raddr;
    logic       src_sel, acc_valid, acc_first, acc_last, vec_done;
`ifdef MVU_WEIGHT_SEQ_PERF_EN
    logic [31:0] vec_count, stall_count;
`endif

    mvu_weight_seq #(.SIMD(2), .PE(2), .MATRIXW(4), .MATRIXH(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .run_i        (run),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .stall_i      (stall),
        .wmem_addr_o  (wmem_addr),
        .ibuf_we_o    (ibuf_we),
        .ibuf_waddr_o (ibuf_waddr),
        .ibuf_raddr_o (ibuf_raddr),
        .src_sel_o    (src_sel),
        .acc_valid_o  (acc_valid),
        .acc_first_o  (acc_first),
        .acc_last_o   (acc_last),
        .vec_done_o   (vec_done)
`ifdef MVU_WEIGHT_SEQ_PERF_EN
        ,
        .vec_count_o  (vec_count),
        .stall_count_o(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Model state: 0 idle, 1 fill, 2 reuse
    int m_st = 0, m_sf = 0, m_nf = 0;
    int m_vecs = 0, m_stalls = 0, seen_done = 0;
    logic [4:0] exp_q[$];

    // One clock: check last edge's delayed outputs, drive inputs, check same-cycle outputs, advance model.
    task automatic cyc(input logic r, input logic rn, input logic v, input logic s);
        logic [4:0] rec, exp_rec;
        logic b, done;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            exp_rec = exp_q.pop_front();
            check("acc_ctl", {27'd0, acc_valid, acc_first, acc_last, src_sel, vec_done}, {27'd0, exp_rec});
            if (vec_done === 1'b1) seen_done++;
        end
        rst = r; run = rn; in_valid = v; stall = s;
        #1;
        b    = ((m_st == 1) && v && !s) || ((m_st == 2) && !s);
        done = b && (m_sf == SF - 1) && (m_nf == NF - 1);
        if (!r) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, (m_st == 1) && !s});
            check("ibuf_we", {31'd0, ibuf_we}, {31'd0, (m_st == 1) && v && !s});
            check("wmem_addr", {30'd0, wmem_addr}, 32'(m_nf * SF + m_sf));
            check("ibuf_addr", {30'd0, ibuf_waddr, ibuf_raddr}, 32'(m_sf * 3));
        end
        rec = r ? 5'b0 : {b, b && (m_sf == 0), b && (m_sf == SF - 1), b && (m_st == 2), done};
        exp_q.push_back(rec);
        if (r) begin
            m_st = 0; m_sf = 0; m_nf = 0; m_vecs = 0; m_stalls = 0;
        end else begin
            if (s && m_st != 0) m_stalls++;
            if (m_st == 0) begin
                if (rn) m_st = 1;
            end else if (b) begin
                if (m_sf < SF - 1) m_sf++;
                else if (m_nf < NF - 1) begin m_sf = 0; m_nf++; m_st = 2; end
                else begin m_sf = 0; m_nf = 0; m_vecs++; m_st = rn ? 1 : 0; end
            end
        end
    endtask

    // Run with given inputs until the model reaches an address/state, bounded.
    task automatic run_to(input int addr, input int st, input logic rn);
        int k = 0;
        while (!((m_nf * SF + m_sf) == addr && m_st == st) && k < 50) begin
            cyc(1'b0, rn, 1'b1, 1'b0);
            k++;
        end
        check("run_to_timeout", k < 50, 1);
    endtask

    initial begin
        // Reset and the very first delayed-output record (all zero)
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("idle_addr", {30'd0, wmem_addr}, 32'd0);

        // Streaming, back-to-back vectors
        for (int i = 0; i < 13; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);

        // in_valid toggling during FILL
        run_to(0, 1, 1'b1);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'(i % 3 != 1), 1'b0);

        // Stall three cycles in REUSE at address 2
        run_to(2, 2, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1);
        check("stall_hold_addr", {30'd0, wmem_addr}, 32'd2);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);

        // run dropped at address 1: vector completes, then parks
        run_to(1, 1, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("parked_state", m_st, 0);
        check("parked_rdy", {31'd0, in_ready}, 32'd0);
        check("parked_addr", {30'd0, wmem_addr}, 32'd0);

        // Reset mid-vector at address 2, then rerun
        run_to(0, 1, 1'b1);
        run_to(2, 2, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_addr", {30'd0, wmem_addr}, 32'd0);
        check("post_rst_rdy", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);

        // Three vectors with exactly five stall cycles, counted from a fresh reset
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++)
            cyc(1'b0, 1'b1, 1'b1, 1'(i == 3 || i == 4 || i == 8 || i == 12 || i == 13));
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("three_vec_model", m_vecs, 3);
        check("five_stall_model", m_stalls, 5);
`ifdef MVU_WEIGHT_SEQ_PERF_EN
        check("vec_count", vec_count, 32'd3);
        check("stall_count", stall_count, 32'd5);
`endif

        // Random traffic
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 7) != 0),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0));
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("final_idle", m_st, 0);
`ifdef MVU_WEIGHT_SEQ_PERF_EN
        check("vec_count_rand", vec_count, 32'(m_vecs));
        check("stall_count_rand", stall_count, 32'(m_stalls));
`endif
        @(negedge clk);
        while (exp_q.size() > 0) begin
            logic [4:0] e;
            e = exp_q.pop_front();
            check("acc_drain", {27'd0, acc_valid, acc_first, acc_last, src_sel, vec_done}, {27'd0, e});
        end
        check("done_pulses_seen", seen_done > 5, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
